// File: rtl/wbm_spi_rx_os_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : wbm_spi_rx_os_pkg                                      |
// | Description : Shared SPI definitions: mode encoding and the rule     |
// |               that selects the sample edge from CPOL/CPHA.           |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package wbm_spi_rx_os_pkg;

  // SPI mode number is {CPOL, CPHA}
  typedef enum logic [1:0] {
    SPI_MODE0 = 2'd0,
    SPI_MODE1 = 2'd1,
    SPI_MODE2 = 2'd2,
    SPI_MODE3 = 2'd3
  } spi_mode_e;

  function automatic spi_mode_e spi_mode(input bit cpol, input bit cpha);
    return spi_mode_e'({cpol, cpha});
  endfunction

  // Data is sampled on the rising SCK edge when CPOL equals CPHA
  function automatic bit sample_on_rise(input spi_mode_e mode);
    return (mode == SPI_MODE0) || (mode == SPI_MODE3);
  endfunction

endpackage
`default_nettype wire

// File: rtl/wbm_spi_rx_os_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : sync_fifo                                              |
// | Description : First-word-fall-through FIFO. A push into a full FIFO  |
// |               succeeds only alongside a pop; otherwise it is dropped |
// |               and a one-cycle overflow pulse is raised.              |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop_req,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_head,
  output logic             o_overflow
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_cw = c_aw + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_wr_ptr;
  logic [c_aw-1:0]  r_rd_ptr;
  logic [c_cw-1:0]  r_count;
  logic             r_overflow;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_wr;
  logic w_drop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_cw'(DEPTH));
  assign w_pop   = i_pop_req & ~w_empty;
  assign w_wr    = i_push & (~w_full | w_pop);
  assign w_drop  = i_push & w_full & ~w_pop;

  assign o_valid    = ~w_empty;
  assign o_head     = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_overflow = r_overflow;

  // Storage array: written on every accepted push
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH (power of two)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= w_drop;
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/wbm_spi_rx_os.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : wbm_spi_rx_os                                          |
// | Description : Oversampled SPI receiver. SCK/CSn/SDI are synchronised |
// |               into clk, words are assembled and queued in a FIFO     |
// |               together with a first-of-frame flag.                   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module wbm_spi_rx_os #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter bit CPOL        = 1'b0,
  parameter bit CPHA        = 1'b0,
  parameter bit LSB_FIRST   = 1'b0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             spi_sck,
  input  logic             spi_csn,
  input  logic             spi_sdi,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_first,
  output logic             rx_overflow,
  output logic             frame_active
);

  import wbm_spi_rx_os_pkg::*;

  localparam int        c_cnt_w       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam spi_mode_e c_mode        = spi_mode(CPOL, CPHA);
  localparam bit        c_sample_rise = sample_on_rise(c_mode);

  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_csn_sync;
  logic [SYNC_STAGES-1:0] r_sdi_sync;
  logic [SYNC_STAGES-1:0] r_warm;
  logic                   r_sck_d;
  logic                   r_csn_d;
  logic                   r_armed;

  logic [c_cnt_w-1:0]     r_cnt;
  logic [WIDTH-1:0]       r_shift;
  logic [WIDTH-1:0]       r_push_word;
  logic                   r_push;
  logic                   r_first;

  logic                   w_sck_s;
  logic                   w_csn_s;
  logic                   w_sdi_s;
  logic                   w_sample;
  logic                   w_csn_fall;
  logic                   w_csn_rise;
  logic                   w_take;
  logic                   w_last;
  logic [WIDTH-1:0]       w_shift_next;
  logic [WIDTH:0]         w_head;

  assign w_sck_s = r_sck_sync[SYNC_STAGES-1];
  assign w_csn_s = r_csn_sync[SYNC_STAGES-1];
  assign w_sdi_s = r_sdi_sync[SYNC_STAGES-1];

  // Input synchronisers plus one delay flop each on SCK and CSn for edge detection;
  // r_warm marks when the chains hold only genuine pin samples after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sck_sync <= {SYNC_STAGES{CPOL}};
      r_csn_sync <= '1;
      r_sdi_sync <= '0;
      r_warm     <= '0;
      r_sck_d    <= CPOL;
      r_csn_d    <= 1'b1;
    end else begin
      r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], spi_sck};
      r_csn_sync <= {r_csn_sync[SYNC_STAGES-2:0], spi_csn};
      r_sdi_sync <= {r_sdi_sync[SYNC_STAGES-2:0], spi_sdi};
      r_warm     <= {r_warm[SYNC_STAGES-2:0], 1'b1};
      r_sck_d    <= w_sck_s;
      r_csn_d    <= w_csn_s;
    end
  end

  // Arm only once a real high CSn has been seen, so a frame in flight at reset release is ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_armed <= 1'b0;
    end else if (r_warm[SYNC_STAGES-1] && w_csn_s) begin
      r_armed <= 1'b1;
    end
  end

  assign frame_active = r_armed & ~w_csn_s;
  assign w_csn_fall   = r_armed & r_csn_d & ~w_csn_s;
  assign w_csn_rise   = r_armed & ~r_csn_d & w_csn_s;
  assign w_sample     = c_sample_rise ? (w_sck_s & ~r_sck_d) : (~w_sck_s & r_sck_d);
  // A sample edge in the same cycle CSn rises still belongs to the frame
  assign w_take       = w_sample & (frame_active | w_csn_rise);
  assign w_last       = (r_cnt == c_cnt_w'(WIDTH - 1));

  if (LSB_FIRST) begin : g_lsb_first
    assign w_shift_next = {w_sdi_s, r_shift[WIDTH-1:1]};
  end else begin : g_msb_first
    assign w_shift_next = {r_shift[WIDTH-2:0], w_sdi_s};
  end

  // Bit counter and shift register; a completed word is staged for a push next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_shift     <= '0;
      r_push      <= 1'b0;
      r_push_word <= '0;
    end else begin
      r_push <= 1'b0;
      if (w_take) begin
        r_cnt   <= (w_last || w_csn_rise) ? '0 : r_cnt + 1'b1;
        r_shift <= w_csn_rise ? '0 : w_shift_next;
        if (w_last) begin
          r_push      <= 1'b1;
          r_push_word <= w_shift_next;
        end
      end else if (!frame_active) begin
        r_cnt   <= '0;
        r_shift <= '0;
      end
    end
  end

  // First-of-frame flag: set on CSn fall, consumed by the next push
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_first <= 1'b0;
    end else if (w_csn_fall) begin
      r_first <= 1'b1;
    end else if (r_push) begin
      r_first <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH (WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (r_push),
    .i_push_data ({r_first, r_push_word}),
    .i_pop_req   (rx_ready),
    .o_valid     (rx_valid),
    .o_head      (w_head),
    .o_overflow  (rx_overflow)
  );

  assign rx_first = w_head[WIDTH];
  assign rx_data  = w_head[WIDTH-1:0];

endmodule
`default_nettype wire
